// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite compositor.
//   dir_t       one-hot sprite direction (Up/Down/Left/Right)
//   tank_st_t   per-tank life-cycle state
//   obj_cls_t   class of the object that won a pixel
//   rgb_t       4-bit-per-channel colour
package sprite_pkg;

   typedef logic [3:0] dir_t;

   localparam dir_t DIR_UP    = 4'b0001;
   localparam dir_t DIR_DOWN  = 4'b0010;
   localparam dir_t DIR_LEFT  = 4'b0100;
   localparam dir_t DIR_RIGHT = 4'b1000;

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      EXPL  = 2'd1,
      DEAD  = 2'd2
   } tank_st_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_TANK   = 2'd1,
      CLS_EXPL   = 2'd2,
      CLS_BULLET = 2'd3
   } obj_cls_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb_t;

   localparam rgb_t TRANSPARENT = 12'h000;
   localparam int unsigned EXPL_FRAMES = 3;

   function automatic logic dir_valid(input dir_t d);
      return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
   endfunction

   // ROM bank index; non-one-hot codes map to 0 and are filtered downstream.
   function automatic logic [1:0] dir_index(input dir_t d);
      case (d)
         DIR_UP:    return 2'd0;
         DIR_DOWN:  return 2'd1;
         DIR_LEFT:  return 2'd2;
         DIR_RIGHT: return 2'd3;
         default:   return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sprite_rom_bank.sv
// Sprite texel ROMs: tank (4 dirs), bullet (4 dirs) and explosion (3 frames), sharing one
// address and one registered output.
//   clk      pixel clock
//   cls      obj_cls_t of the selected object (selects ROM family)
//   dir_idx  direction index 0..3 (Up/Down/Left/Right)
//   addr     {frame, dy, dx} for explosions, {dy, dx} otherwise
//   data     texel colour, valid one clock after addr
// Contents are generated arithmetically:
//   tank      {dir+1, addr[7:4], addr[3:0]}, transparent in the right-most column
//   bullet    {8+dir, addr[5:4], addr[3:0]}, transparent in the right-most column
//   explosion {E, {addr[2TW-1 -: 2], frame+1}, addr[3:0]}
module sprite_rom_bank
   import sprite_pkg::*;
#(
   parameter int unsigned TANK_SZ   = 32,
   parameter int unsigned BULLET_SZ = 8,
   parameter int unsigned ADDR_W    = 12
) (
   input  logic              clk,
   input  logic [1:0]        cls,
   input  logic [1:0]        dir_idx,
   input  logic [ADDR_W-1:0] addr,
   output logic [11:0]       data
);

   localparam int unsigned TW = $clog2(TANK_SZ);
   localparam int unsigned BW = $clog2(BULLET_SZ);

   rgb_t tank_texel;
   rgb_t bullet_texel;
   rgb_t expl_texel;
   rgb_t texel;

   always_comb begin
      tank_texel = '{r: 4'(dir_idx) + 4'd1, g: addr[7:4], b: addr[3:0]};
      if (addr[TW-1:0] == TW'(TANK_SZ - 1)) begin
         tank_texel = TRANSPARENT;
      end

      bullet_texel = '{r: 4'd8 + 4'(dir_idx), g: {2'b00, addr[5:4]}, b: addr[3:0]};
      if (addr[BW-1:0] == BW'(BULLET_SZ - 1)) begin
         bullet_texel = TRANSPARENT;
      end

      expl_texel = '{r: 4'hE,
                     g: {addr[2*TW-1 -: 2], addr[ADDR_W-1 -: 2] + 2'd1},
                     b: addr[3:0]};

      case (obj_cls_t'(cls))
         CLS_TANK:   texel = tank_texel;
         CLS_BULLET: texel = bullet_texel;
         CLS_EXPL:   texel = expl_texel;
         default:    texel = TRANSPARENT;
      endcase
   end

   always_ff @(posedge clk) begin
      data <= texel;
   end

endmodule

// File: rtl/sprite_compositor.sv
// Composites N tanks and M bullets into a registered RGB stream, 2-cycle latency, 1 px/clk.
//   vga_clk, reset_n            pixel clock, async active-low reset
//   frame_start                 one pulse per frame, paces explosion animation
//   DrawX, DrawY                current pixel
//   tank_x/y/dir/show           packed per-tank position, one-hot dir, enable
//   tank_hit, tank_respawn      per-tank pulses driving the ALIVE/EXPL/DEAD FSM
//   bullet_x/y/dir/show         packed per-bullet position, one-hot dir, enable
//   red, green, blue            registered pixel colour
//   pix_valid                   a non-transparent sprite pixel was drawn
//   bullet_pix                  one-hot: which bullet drew the pixel
//   tank_alive                  per-tank state == ALIVE
module sprite_compositor
   import sprite_pkg::*;
#(
   parameter int unsigned N_TANKS   = 4,
   parameter int unsigned N_BULLETS = 4,
   parameter int unsigned TANK_SZ   = 32,
   parameter int unsigned BULLET_SZ = 8,
   parameter int unsigned EXPL_HOLD = 4
) (
   input  logic                   vga_clk,
   input  logic                   reset_n,
   input  logic                   frame_start,
   input  logic [9:0]             DrawX,
   input  logic [9:0]             DrawY,
   input  logic [N_TANKS*10-1:0]  tank_x,
   input  logic [N_TANKS*10-1:0]  tank_y,
   input  logic [N_TANKS*4-1:0]   tank_dir,
   input  logic [N_TANKS-1:0]     tank_show,
   input  logic [N_TANKS-1:0]     tank_hit,
   input  logic [N_TANKS-1:0]     tank_respawn,
   input  logic [N_BULLETS*10-1:0] bullet_x,
   input  logic [N_BULLETS*10-1:0] bullet_y,
   input  logic [N_BULLETS*4-1:0] bullet_dir,
   input  logic [N_BULLETS-1:0]   bullet_show,
   output logic [3:0]             red,
   output logic [3:0]             green,
   output logic [3:0]             blue,
   output logic                   pix_valid,
   output logic [N_BULLETS-1:0]   bullet_pix,
   output logic [N_TANKS-1:0]     tank_alive
);

   localparam int unsigned TW     = $clog2(TANK_SZ);
   localparam int unsigned BW     = $clog2(BULLET_SZ);
   localparam int unsigned FW     = $clog2(EXPL_FRAMES);
   localparam int unsigned ADDR_W = FW + 2 * TW;
   localparam int unsigned BIDX_W = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

   logic [N_TANKS-1:0]   tank_cov;
   logic [N_TANKS-1:0]   tank_expl;
   logic [TW-1:0]        tank_dx  [N_TANKS];
   logic [TW-1:0]        tank_dy  [N_TANKS];
   logic [FW-1:0]        tank_frm [N_TANKS];
   logic [N_BULLETS-1:0] bul_cov;
   logic [BW-1:0]        bul_dx [N_BULLETS];
   logic [BW-1:0]        bul_dy [N_BULLETS];

   // ---------------- per-tank hit test and life-cycle FSM ----------------
   for (genvar i = 0; i < N_TANKS; i++) begin : g_tank
      tank_st_t      st_q, st_d;
      logic [FW-1:0] frm_q, frm_d;
      logic [3:0]    cnt_q, cnt_d;
      logic [9:0]    tx, ty;
      logic          in_x, in_y;
      logic          alive, expl, drawable;

      assign tx = tank_x[i*10 +: 10];
      assign ty = tank_y[i*10 +: 10];
      // 11-bit upper bound so a sprite near 1023 never wraps onto column 0.
      assign in_x = (DrawX >= tx) && ({1'b0, DrawX} < {1'b0, tx} + 11'(TANK_SZ));
      assign in_y = (DrawY >= ty) && ({1'b0, DrawY} < {1'b0, ty} + 11'(TANK_SZ));

      always_ff @(posedge vga_clk or negedge reset_n) begin
         if (!reset_n) begin
            st_q  <= ALIVE;
            frm_q <= '0;
            cnt_q <= '0;
         end else begin
            st_q  <= st_d;
            frm_q <= frm_d;
            cnt_q <= cnt_d;
         end
      end

      always_comb begin
         st_d  = st_q;
         frm_d = frm_q;
         cnt_d = cnt_q;
         case (st_q)
            ALIVE: begin
               // A frame_start coinciding with the hit is not counted.
               if (tank_hit[i]) begin
                  st_d  = EXPL;
                  frm_d = '0;
                  cnt_d = '0;
               end
            end
            EXPL: begin
               if (frame_start) begin
                  if (cnt_q == 4'(EXPL_HOLD - 1)) begin
                     cnt_d = '0;
                     if (frm_q == FW'(EXPL_FRAMES - 1)) begin
                        st_d = DEAD;
                     end else begin
                        frm_d = frm_q + 1'b1;
                     end
                  end else begin
                     cnt_d = cnt_q + 4'd1;
                  end
               end
            end
            DEAD: begin
               if (tank_respawn[i]) begin
                  st_d = ALIVE;
               end
            end
            default: st_d = ALIVE;
         endcase
      end

      always_comb begin
         alive    = (st_q == ALIVE);
         expl     = (st_q == EXPL);
         drawable = tank_show[i] && (st_q != DEAD);
      end

      assign tank_alive[i] = alive;
      assign tank_expl[i]  = expl;
      assign tank_cov[i]   = drawable && in_x && in_y;
      assign tank_dx[i]    = TW'(DrawX - tx);
      assign tank_dy[i]    = TW'(DrawY - ty);
      assign tank_frm[i]   = frm_q;
   end

   // ---------------- per-bullet hit test ----------------
   for (genvar i = 0; i < N_BULLETS; i++) begin : g_bullet
      logic [9:0] bx, by;
      logic       in_x, in_y;

      assign bx   = bullet_x[i*10 +: 10];
      assign by   = bullet_y[i*10 +: 10];
      assign in_x = (DrawX >= bx) && ({1'b0, DrawX} < {1'b0, bx} + 11'(BULLET_SZ));
      assign in_y = (DrawY >= by) && ({1'b0, DrawY} < {1'b0, by} + 11'(BULLET_SZ));

      assign bul_cov[i] = bullet_show[i] && in_x && in_y;
      assign bul_dx[i]  = BW'(DrawX - bx);
      assign bul_dy[i]  = BW'(DrawY - by);
   end

   // ---------------- S0: priority select ----------------
   obj_cls_t          s0_cls;
   dir_t              s0_dir;
   logic              s0_dir_ok;
   logic [ADDR_W-1:0] s0_addr;
   logic [BIDX_W-1:0] s0_bidx;

   // Descending scans so the lowest index is the last to write; bullets follow tanks so
   // any bullet beats any tank.
   always_comb begin
      s0_cls  = CLS_NONE;
      s0_dir  = '0;
      s0_addr = '0;
      s0_bidx = '0;
      for (int i = int'(N_TANKS) - 1; i >= 0; i--) begin
         if (tank_cov[i]) begin
            s0_cls  = tank_expl[i] ? CLS_EXPL : CLS_TANK;
            s0_dir  = tank_dir[i*4 +: 4];
            s0_addr = tank_expl[i] ? {tank_frm[i], tank_dy[i], tank_dx[i]}
                                   : {FW'(0), tank_dy[i], tank_dx[i]};
         end
      end
      for (int i = int'(N_BULLETS) - 1; i >= 0; i--) begin
         if (bul_cov[i]) begin
            s0_cls  = CLS_BULLET;
            s0_dir  = bullet_dir[i*4 +: 4];
            s0_addr = ADDR_W'({bul_dy[i], bul_dx[i]});
            s0_bidx = BIDX_W'(i);
         end
      end
      // Explosions are drawn whatever the tank's direction.
      s0_dir_ok = dir_valid(s0_dir) || (s0_cls == CLS_EXPL);
   end

   // ---------------- S1: ROM read with select registered alongside ----------------
   logic [11:0]       rom_data;
   obj_cls_t          cls_q;
   logic              dir_ok_q;
   logic [BIDX_W-1:0] bidx_q;

   sprite_rom_bank #(
      .TANK_SZ   (TANK_SZ),
      .BULLET_SZ (BULLET_SZ),
      .ADDR_W    (ADDR_W)
   ) u_rom (
      .clk     (vga_clk),
      .cls     (s0_cls),
      .dir_idx (dir_index(s0_dir)),
      .addr    (s0_addr),
      .data    (rom_data)
   );

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         cls_q    <= CLS_NONE;
         dir_ok_q <= 1'b0;
         bidx_q   <= '0;
      end else begin
         cls_q    <= s0_cls;
         dir_ok_q <= s0_dir_ok;
         bidx_q   <= s0_bidx;
      end
   end

   // ---------------- S2: transparency / invalid-dir resolve, output register ----------------
   rgb_t                 pix_d, pix_q;
   logic                 valid_d, valid_q;
   logic [N_BULLETS-1:0] bpix_d, bpix_q;

   always_comb begin
      pix_d   = TRANSPARENT;
      valid_d = 1'b0;
      bpix_d  = '0;
      if ((cls_q == CLS_BULLET) && !dir_ok_q) begin
         // A bullet with a corrupt direction is still made visible as a white square.
         pix_d          = 12'hFFF;
         valid_d        = 1'b1;
         bpix_d[bidx_q] = 1'b1;
      end else if ((cls_q != CLS_NONE) && dir_ok_q && (rom_data != TRANSPARENT)) begin
         pix_d   = rom_data;
         valid_d = 1'b1;
         if (cls_q == CLS_BULLET) begin
            bpix_d[bidx_q] = 1'b1;
         end
      end
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         pix_q   <= TRANSPARENT;
         valid_q <= 1'b0;
         bpix_q  <= '0;
      end else begin
         pix_q   <= pix_d;
         valid_q <= valid_d;
         bpix_q  <= bpix_d;
      end
   end

   assign red        = pix_q.r;
   assign green      = pix_q.g;
   assign blue       = pix_q.b;
   assign pix_valid  = valid_q;
   assign bullet_pix = bpix_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: table of still-scene pixels streamed back to back
// through a scoreboard, plus hand sequences for explosion timing, respawn and async reset.
module tb_sprite_compositor;

   localparam int NT = 4;
   localparam int NB = 4;

   logic            vga_clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            frame_start = 1'b0;
   logic [9:0]      DrawX = '0;
   logic [9:0]      DrawY = '0;
   logic [NT*10-1:0] tank_x = '0;
   logic [NT*10-1:0] tank_y = '0;
   logic [NT*4-1:0] tank_dir = '0;
   logic [NT-1:0]   tank_show = '0;
   logic [NT-1:0]   tank_hit = '0;
   logic [NT-1:0]   tank_respawn = '0;
   logic [NB*10-1:0] bullet_x = '0;
   logic [NB*10-1:0] bullet_y = '0;
   logic [NB*4-1:0] bullet_dir = '0;
   logic [NB-1:0]   bullet_show = '0;
   logic [3:0]      red, green, blue;
   logic            pix_valid;
   logic [NB-1:0]   bullet_pix;
   logic [NT-1:0]   tank_alive;

   sprite_compositor #(
      .N_TANKS   (NT),
      .N_BULLETS (NB),
      .TANK_SZ   (32),
      .BULLET_SZ (8),
      .EXPL_HOLD (4)
   ) dut (
      .vga_clk      (vga_clk),
      .reset_n      (reset_n),
      .frame_start  (frame_start),
      .DrawX        (DrawX),
      .DrawY        (DrawY),
      .tank_x       (tank_x),
      .tank_y       (tank_y),
      .tank_dir     (tank_dir),
      .tank_show    (tank_show),
      .tank_hit     (tank_hit),
      .tank_respawn (tank_respawn),
      .bullet_x     (bullet_x),
      .bullet_y     (bullet_y),
      .bullet_dir   (bullet_dir),
      .bullet_show  (bullet_show),
      .red          (red),
      .green        (green),
      .blue         (blue),
      .pix_valid    (pix_valid),
      .bullet_pix   (bullet_pix),
      .tank_alive   (tank_alive)
   );

   always #5 vga_clk = ~vga_clk;

   typedef struct {
      int          due;
      logic [11:0] rgb;
      logic        v;
      logic [3:0]  bp;
      string       name;
   } exp_t;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [11:0] rgb;
      logic        v;
      logic [3:0]  bp;
      string       name;
   } vec_t;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   // Output monitor: compares the scoreboard head once its pixel has reached the output.
   always begin
      @(posedge vga_clk);
      cyc++;
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         n_cmp++;
         if ({red, green, blue, pix_valid, bullet_pix} !== {mon_e.rgb, mon_e.v, mon_e.bp}) begin
            n_bad++;
            $display("FAIL %s: got rgb=%h v=%b bp=%b, want rgb=%h v=%b bp=%b", mon_e.name,
                     {red, green, blue}, pix_valid, bullet_pix, mon_e.rgb, mon_e.v, mon_e.bp);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic px(input logic [9:0] x, input logic [9:0] y, input logic [11:0] rgb,
                     input logic v, input logic [3:0] bp, input string name);
      exp_t e;
      @(negedge vga_clk);
      DrawX  = x;
      DrawY  = y;
      e.due  = cyc + 2;
      e.rgb  = rgb;
      e.v    = v;
      e.bp   = bp;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic drain();
      repeat (3) @(negedge vga_clk);
   endtask

   task automatic pulse(input logic fs, input logic [3:0] hit, input logic [3:0] resp);
      @(negedge vga_clk);
      frame_start  = fs;
      tank_hit     = hit;
      tank_respawn = resp;
      @(negedge vga_clk);
      frame_start  = 1'b0;
      tank_hit     = '0;
      tank_respawn = '0;
   endtask

   task automatic check_alive(input logic [3:0] want, input string name);
      n_cmp++;
      if (tank_alive !== want) begin
         n_bad++;
         $display("FAIL %s: tank_alive got %b want %b", name, tank_alive, want);
      end
   endtask

   task automatic check_out0(input string name);
      n_cmp++;
      if ({red, green, blue, pix_valid, bullet_pix} !== 17'd0) begin
         n_bad++;
         $display("FAIL %s: got rgb=%h v=%b bp=%b, want all zero", name, {red, green, blue},
                  pix_valid, bullet_pix);
      end
   endtask

   initial begin
      vec_t        tbl[18];
      logic [11:0] want;

      // ---- reset state ----
      repeat (3) @(negedge vga_clk);
      check_out0("reset_outputs");
      check_alive(4'hF, "reset_alive");
      reset_n = 1'b1;

      // ---- nothing shown: every pixel is background ----
      px(10'd0,    10'd0,   12'h000, 1'b0, 4'h0, "idle_0_0");
      px(10'd100,  10'd50,  12'h000, 1'b0, 4'h0, "idle_100_50");
      px(10'd640,  10'd479, 12'h000, 1'b0, 4'h0, "idle_640_479");
      px(10'd1023, 10'd1023, 12'h000, 1'b0, 4'h0, "idle_max");
      drain();
      check_alive(4'hF, "idle_alive");

      // ---- still scene ----
      tank_x[0*10 +: 10] = 10'd100;  tank_y[0*10 +: 10] = 10'd50;  tank_dir[0*4 +: 4] = 4'b0001;
      tank_x[1*10 +: 10] = 10'd1000; tank_y[1*10 +: 10] = 10'd200; tank_dir[1*4 +: 4] = 4'b1000;
      tank_x[2*10 +: 10] = 10'd300;  tank_y[2*10 +: 10] = 10'd300; tank_dir[2*4 +: 4] = 4'b0100;
      tank_x[3*10 +: 10] = 10'd400;  tank_y[3*10 +: 10] = 10'd100; tank_dir[3*4 +: 4] = 4'b0000;
      tank_show = 4'hF;
      bullet_x[0*10 +: 10] = 10'd600; bullet_y[0*10 +: 10] = 10'd400; bullet_dir[0*4 +: 4] = 4'b0000;
      bullet_x[1*10 +: 10] = 10'd110; bullet_y[1*10 +: 10] = 10'd60;  bullet_dir[1*4 +: 4] = 4'b0001;
      bullet_x[2*10 +: 10] = 10'd114; bullet_y[2*10 +: 10] = 10'd62;  bullet_dir[2*4 +: 4] = 4'b0010;
      bullet_x[3*10 +: 10] = 10'd100; bullet_y[3*10 +: 10] = 10'd50;  bullet_dir[3*4 +: 4] = 4'b0001;
      bullet_show = 4'b0111;

      tbl[0]  = '{10'd100,  10'd50,  12'h100, 1'b1, 4'h0, "tank0_up_rom0"};
      tbl[1]  = '{10'd132,  10'd50,  12'h000, 1'b0, 4'h0, "tank0_right_edge_out"};
      tbl[2]  = '{10'd131,  10'd50,  12'h000, 1'b0, 4'h0, "tank0_transparent_col"};
      tbl[3]  = '{10'd112,  10'd61,  12'h80A, 1'b1, 4'b0010, "bullet1_over_tank_rom10"};
      tbl[4]  = '{10'd115,  10'd63,  12'h81D, 1'b1, 4'b0010, "bullet1_beats_bullet2"};
      tbl[5]  = '{10'd121,  10'd69,  12'h000, 1'b0, 4'h0, "bullet2_transparent_no_fallthru"};
      tbl[6]  = '{10'd120,  10'd69,  12'h93E, 1'b1, 4'b0100, "bullet2_down_rom62"};
      tbl[7]  = '{10'd5,    10'd200, 12'h000, 1'b0, 4'h0, "tank1_no_wrap"};
      tbl[8]  = '{10'd1010, 10'd205, 12'h4AA, 1'b1, 4'h0, "tank1_right_near_edge"};
      tbl[9]  = '{10'd1023, 10'd231, 12'h4F7, 1'b1, 4'h0, "tank1_corner_1023"};
      tbl[10] = '{10'd310,  10'd305, 12'h3AA, 1'b1, 4'h0, "tank2_left"};
      tbl[11] = '{10'd400,  10'd100, 12'h000, 1'b0, 4'h0, "tank3_bad_dir_transparent"};
      tbl[12] = '{10'd600,  10'd400, 12'hFFF, 1'b1, 4'b0001, "bullet0_bad_dir_white"};
      tbl[13] = '{10'd607,  10'd407, 12'hFFF, 1'b1, 4'b0001, "bullet0_bad_dir_white_edge"};
      tbl[14] = '{10'd99,   10'd50,  12'h000, 1'b0, 4'h0, "tank0_left_of_box"};
      tbl[15] = '{10'd100,  10'd49,  12'h000, 1'b0, 4'h0, "tank0_above_box"};
      tbl[16] = '{10'd100,  10'd81,  12'h1E0, 1'b1, 4'h0, "tank0_bottom_row"};
      tbl[17] = '{10'd100,  10'd82,  12'h000, 1'b0, 4'h0, "tank0_below_box"};

      // Back to back: one pixel per clock through the pipeline.
      for (int i = 0; i < 18; i++) begin
         px(tbl[i].x, tbl[i].y, tbl[i].rgb, tbl[i].v, tbl[i].bp, tbl[i].name);
      end
      drain();

      // ---- explosion of tank2: hit, respawn and frame_start all in the same cycle ----
      pulse(1'b1, 4'b0100, 4'b0100);
      check_alive(4'b1011, "hit_enters_expl");
      px(10'd310, 10'd305, 12'hE1A, 1'b1, 4'h0, "expl_frame0_start");
      drain();

      for (int p = 1; p <= 12; p++) begin
         // A second hit and a respawn mid-explosion must both be ignored.
         if (p == 5) pulse(1'b1, 4'b0100, 4'b0100);
         else        pulse(1'b1, 4'b0000, 4'b0000);
         want = (p < 12) ? {4'hE, 4'(p / 4 + 1), 4'hA} : 12'h000;
         px(10'd310, 10'd305, want, (p < 12), 4'h0, $sformatf("expl_after_fs%0d", p));
         drain();
         if (p == 6) begin
            tank_show[2] = 1'b0;
            px(10'd310, 10'd305, 12'h000, 1'b0, 4'h0, "expl_hidden_by_show");
            drain();
            tank_show[2] = 1'b1;
         end
      end
      check_alive(4'b1011, "expl_done_dead");

      // ---- DEAD: hit ignored, respawn revives next cycle ----
      pulse(1'b0, 4'b0100, 4'b0000);
      check_alive(4'b1011, "dead_ignores_hit");
      px(10'd310, 10'd305, 12'h000, 1'b0, 4'h0, "dead_not_drawn");
      drain();
      pulse(1'b0, 4'b0000, 4'b0100);
      check_alive(4'hF, "respawn_alive");
      px(10'd310, 10'd305, 12'h3AA, 1'b1, 4'h0, "respawn_drawn");
      drain();

      // ---- async reset in the middle of an explosion ----
      pulse(1'b0, 4'b0100, 4'b0000);
      pulse(1'b1, 4'b0000, 4'b0000);
      pulse(1'b1, 4'b0000, 4'b0000);
      px(10'd600, 10'd400, 12'hFFF, 1'b1, 4'b0001, "pre_reset_white");
      drain();
      check_alive(4'b1011, "pre_reset_expl");
      @(posedge vga_clk);
      #2;
      reset_n = 1'b0;
      #1;
      check_out0("mid_expl_reset_outputs");
      check_alive(4'hF, "mid_expl_reset_alive");
      @(negedge vga_clk);
      reset_n = 1'b1;
      px(10'd310, 10'd305, 12'h3AA, 1'b1, 4'h0, "post_reset_tank_alive");
      drain();

      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drained: %0d left, want 0", sb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
